// File: rtl/checksum_stream.sv
// Streaming ones-complement checksum with three pipeline stages.
// The stages are beat partial sum, packet accumulator, and checksum output register.
module checksum_stream #(
    parameter int DATA_W   = 64,
    parameter int SUM_W    = 16,
    parameter int ZERO_FIX = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic [DATA_W/8-1:0]   keep_i,
    input  logic                  last_i,
    input  logic [SUM_W-1:0]      seed_i,
    output logic                  cs_valid_o,
    output logic [SUM_W-1:0]      cs_o
);
    localparam int BPW = SUM_W / 8;
    localparam int NW  = DATA_W / SUM_W;
    localparam int LG  = $clog2(NW);
    localparam int TW  = SUM_W + LG;

    function automatic logic [SUM_W-1:0] fold(input logic [SUM_W:0] x);
        return x[SUM_W-1:0] + SUM_W'(x[SUM_W]);
    endfunction

    // Masked beat regrouped into words, first wire byte in the word MSB.
    logic [DATA_W-1:0] words;
    genvar gi, gb, gl;
    generate
        for (gi = 0; gi < NW; gi++) begin : g_word
            for (gb = 0; gb < BPW; gb++) begin : g_byte
                assign words[gi*SUM_W + SUM_W - 8 - 8*gb +: 8] =
                    keep_i[gi*BPW + gb] ? data_i[8*(gi*BPW + gb) +: 8] : 8'h00;
            end
        end

        for (gl = 0; gl <= LG; gl++) begin : g_lvl
            logic [TW-1:0] node [NW >> gl];
            for (gi = 0; gi < (NW >> gl); gi++) begin : g_node
                if (gl == 0) begin : g_leaf
                    assign node[gi] = TW'(words[gi*SUM_W +: SUM_W]);
                end else begin : g_add
                    assign node[gi] = g_lvl[gl-1].node[2*gi] + g_lvl[gl-1].node[2*gi+1];
                end
            end
        end
    endgenerate

    logic [TW-1:0]    tree_sum;
    logic [SUM_W:0]   fold1_sum;
    logic [SUM_W-1:0] beat_sum;

    assign tree_sum  = g_lvl[LG].node[0];
    assign fold1_sum = {1'b0, tree_sum[SUM_W-1:0]} + (SUM_W+1)'(tree_sum[TW-1:SUM_W]);
    assign beat_sum  = fold(fold1_sum);

    logic             first_reg;
    logic             p1_valid_reg;
    logic             p1_last_reg;
    logic             p1_first_reg;
    logic [SUM_W-1:0] p1_sum_reg;
    logic [SUM_W-1:0] p1_seed_reg;
    logic [SUM_W-1:0] acc_reg;
    logic             done_reg;
    logic [SUM_W-1:0] acc_next;
    logic [SUM_W-1:0] cs_next;

    always_comb begin
        acc_next = fold({1'b0, p1_first_reg ? p1_seed_reg : acc_reg} + {1'b0, p1_sum_reg});
        cs_next  = ~acc_reg;
        if (ZERO_FIX != 0 && cs_next == '0) begin
            cs_next = '1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_reg    <= 1'b1;
            p1_valid_reg <= 1'b0;
            p1_last_reg  <= 1'b0;
            p1_first_reg <= 1'b0;
            p1_sum_reg   <= '0;
            p1_seed_reg  <= '0;
            acc_reg      <= '0;
            done_reg     <= 1'b0;
            cs_valid_o   <= 1'b0;
            cs_o         <= '0;
        end else begin
            p1_valid_reg <= valid_i;
            if (valid_i) begin
                first_reg    <= last_i;
                p1_last_reg  <= last_i;
                p1_first_reg <= first_reg;
                p1_sum_reg   <= beat_sum;
                p1_seed_reg  <= seed_i;
            end

            done_reg <= p1_valid_reg & p1_last_reg;
            if (p1_valid_reg) begin
                acc_reg <= acc_next;
            end

            // The output stage reads acc_reg before a following packet overwrites it.
            cs_valid_o <= done_reg;
            if (done_reg) begin
                cs_o <= cs_next;
            end
        end
    end
endmodule

// File: tb/tb_checksum_stream.sv
// Directed bench for checksum_stream with a 32-bit beat.
// Two instances (ZERO_FIX off and on) share the same stimulus.
module tb_checksum_stream;
    logic        clk;
    logic        reset;
    logic        valid;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [15:0] seed;
    logic        cs_valid0, cs_valid1;
    logic [15:0] cs0, cs1;

    int n_checks = 0;
    int n_pass   = 0;

    checksum_stream #(.DATA_W(32), .SUM_W(16), .ZERO_FIX(0)) dut0 (
        .clk(clk), .reset(reset), .valid_i(valid), .data_i(data), .keep_i(keep),
        .last_i(last), .seed_i(seed), .cs_valid_o(cs_valid0), .cs_o(cs0)
    );

    checksum_stream #(.DATA_W(32), .SUM_W(16), .ZERO_FIX(1)) dut1 (
        .clk(clk), .reset(reset), .valid_i(valid), .data_i(data), .keep_i(keep),
        .last_i(last), .seed_i(seed), .cs_valid_o(cs_valid1), .cs_o(cs1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat at the next edge, then fill the idle bus with junk.
    task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l,
                         input logic [15:0] s);
        valid = 1'b1;
        data  = d;
        keep  = k;
        last  = l;
        seed  = s;
        @(posedge clk);
        #1;
        valid = 1'b0;
        data  = $urandom;
        keep  = 4'($urandom);
        last  = 1'b1;
        seed  = 16'($urandom);
    endtask

    // Expects the pulse two edges after the beat's own edge, then a held value.
    task automatic expect_pkt(input string tag, input logic [15:0] exp);
        logic [15:0] exp1;
        exp1 = (exp == 16'h0000) ? 16'hFFFF : exp;
        idle(1);
        check({tag, "_early"}, 32'(cs_valid0), 32'd0);
        idle(1);
        check({tag, "_vld"}, 32'(cs_valid0), 32'd1);
        check({tag, "_cs"}, 32'(cs0), 32'(exp));
        check({tag, "_cs_zf"}, 32'(cs1), 32'(exp1));
        $display("txn %s: cs=%h cs_zf=%h", tag, cs0, cs1);
        idle(1);
        check({tag, "_pulse_end"}, 32'(cs_valid0), 32'd0);
        check({tag, "_hold"}, 32'(cs0), 32'(exp));
    endtask

    initial begin
        reset = 1'b1;
        valid = 1'b0;
        data  = '0;
        keep  = '0;
        last  = 1'b0;
        seed  = '0;
        idle(2);
        check("rst_vld", 32'(cs_valid0), 32'd0);
        check("rst_cs", 32'(cs0), 32'd0);
        reset = 1'b0;
        idle(1);

        drive(32'h04030201, 4'hF, 1'b1, 16'h0000);
        expect_pkt("simple", 16'hFBF9);

        drive(32'h0100FFFF, 4'hF, 1'b1, 16'h0000);
        expect_pkt("carry", 16'hFFFE);

        // Two beats with an idle gap; the seed on the second beat must be ignored.
        drive(32'h04030201, 4'hF, 1'b0, 16'h0000);
        idle(1);
        drive(32'hAA030201, 4'h7, 1'b1, 16'h1234);
        check("two_beat_no_early_pulse", 32'(cs_valid0), 32'd0);
        expect_pkt("two_beat", 16'hF7F7);

        drive(32'hAA030201, 4'h7, 1'b1, 16'h0000);
        expect_pkt("keep7", 16'hFBFD);

        drive(32'h0000FFFF, 4'hF, 1'b1, 16'h0000);
        expect_pkt("zero", 16'h0000);

        drive(32'h04030201, 4'hF, 1'b1, 16'h0000);
        drive(32'h04030201, 4'hF, 1'b1, 16'h0001);
        drive(32'h04030201, 4'hF, 1'b1, 16'h0000);
        check("b2b_1_vld", 32'(cs_valid0), 32'd1);
        check("b2b_1_cs", 32'(cs0), 32'hFBF9);
        $display("txn b2b_1: cs=%h", cs0);
        idle(1);
        check("b2b_2_vld", 32'(cs_valid0), 32'd1);
        check("b2b_2_cs", 32'(cs0), 32'hFBF8);
        $display("txn b2b_2: cs=%h", cs0);
        idle(1);
        check("b2b_3_vld", 32'(cs_valid0), 32'd1);
        check("b2b_3_cs", 32'(cs0), 32'hFBF9);
        $display("txn b2b_3: cs=%h", cs0);
        idle(1);
        check("b2b_end", 32'(cs_valid0), 32'd0);

        // Reset lands right after beat 1 is captured in stage 1.
        drive(32'h04030201, 4'hF, 1'b0, 16'h0000);
        reset = 1'b1;
        #1;
        check("midrst_vld", 32'(cs_valid0), 32'd0);
        check("midrst_cs", 32'(cs0), 32'd0);
        idle(1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("midrst_no_pulse", 32'(cs_valid0), 32'd0);
        end
        drive(32'h04030201, 4'hF, 1'b1, 16'h0000);
        expect_pkt("after_rst", 16'hFBF9);
        drive(32'h04030201, 4'hF, 1'b1, 16'h0001);
        expect_pkt("after_rst_seed", 16'hFBF8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
